// File: rtl/apb_pkg.sv
// apb_pkg: shared APB master types and constants.
// Bus widths, PSEL decode field and FSM states.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_e;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;
  localparam int APB_PSEL_W = 16;
  localparam int PSEL_MSB   = 15;
  localparam int PSEL_LSB   = 12;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter with internal pointer.
// Search starts one past the last winner and wraps.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int LW = (N > 1) ? $clog2(N) : 1;

  logic [LW-1:0] last_q, last_d;
  logic          found;

  // first requester above the pointer, else lowest one
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (i > int'(last_q))) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  // remember the winner once the grant is taken
  always_comb begin
    last_d = last_q;
    for (int i = 0; i < N; i++) begin
      if (advance && grant[i]) last_d = LW'(i);
    end
  end

  // pointer register; reset makes index 0 win first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= LW'(N - 1);
    else        last_q <= last_d;
  end

endmodule

// File: rtl/apb_master_arb.sv
// apb_master_arb: multi-requester APB master.
// Round-robin grant, SETUP/ACCESS phases, timeout abort.
module apb_master_arb
  import apb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 256
) (
  input  logic                             PCLK,
  input  logic                             PRESETn,
  input  logic [NREQ-1:0]                  req_valid,
  output logic [NREQ-1:0]                  req_ready,
  input  logic [NREQ-1:0][APB_ADDR_W-1:0]  req_addr,
  input  logic [NREQ-1:0][APB_DATA_W-1:0]  req_wdata,
  input  logic [NREQ-1:0]                  req_write,
  output logic [NREQ-1:0]                  rsp_valid,
  output logic [APB_DATA_W-1:0]            rsp_rdata,
  output logic                             rsp_err,
  output logic [APB_ADDR_W-1:0]            PADDR,
  output logic [APB_DATA_W-1:0]            PWDATA,
  output logic [APB_PSEL_W-1:0]            PSEL,
  output logic                             PENABLE,
  output logic                             PWRITE,
  input  logic                             PREADY,
  input  logic [APB_DATA_W-1:0]            PRDATA
);

  localparam int CW = $clog2(TIMEOUT + 1);

  apb_state_e            state_q, state_d;
  logic [APB_ADDR_W-1:0] addr_q, addr_d;
  logic [APB_DATA_W-1:0] wdata_q, wdata_d;
  logic                  write_q, write_d;
  logic [NREQ-1:0]       owner_q, owner_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [NREQ-1:0]       ready_q, ready_d;
  logic [NREQ-1:0]       rspv_q, rspv_d;
  logic [APB_DATA_W-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [NREQ-1:0]       gnt;
  logic                  adv;

  rr_arbiter #(.N(NREQ)) u_arb (
    .clk     (PCLK),
    .rst_n   (PRESETn),
    .req     (req_valid),
    .advance (adv),
    .grant   (gnt)
  );

  // transfer sequencing: grant, setup, access, complete
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    ready_d = '0;
    rspv_d  = '0;
    rdata_d = '0;
    err_d   = 1'b0;
    adv     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          adv     = 1'b1;
          ready_d = gnt;
          owner_d = gnt;
          cnt_d   = '0;
          for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
              addr_d  = req_addr[i];
              wdata_d = req_wdata[i];
              write_d = req_write[i];
            end
          end
          state_d = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          rspv_d  = owner_q;
          rdata_d = write_q ? '0 : PRDATA;
          state_d = IDLE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          rspv_d  = owner_q;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and captured request registers
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      owner_q <= '0;
      cnt_q   <= '0;
      ready_q <= '0;
      rspv_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      rspv_q  <= rspv_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // slave select decoded from the held address
  always_comb begin
    PSEL = '0;
    if (state_q != IDLE) PSEL[addr_q[PSEL_MSB:PSEL_LSB]] = 1'b1;
  end

  assign PENABLE   = (state_q == ACCESS);
  assign PADDR     = addr_q;
  assign PWDATA    = wdata_q;
  assign PWRITE    = write_q;
  assign req_ready = ready_q;
  assign rsp_valid = rspv_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_apb_master_arb.sv
// tb_apb_master_arb: directed and random checks of the
// APB arbiter against a round-robin transaction model.
module tb_apb_master_arb;

  localparam int NR  = 4;
  localparam int TMO = 8;

  logic                 PCLK;
  logic                 PRESETn;
  logic [NR-1:0]        req_valid;
  logic [NR-1:0]        req_ready;
  logic [NR-1:0][31:0]  req_addr;
  logic [NR-1:0][31:0]  req_wdata;
  logic [NR-1:0]        req_write;
  logic [NR-1:0]        rsp_valid;
  logic [31:0]          rsp_rdata;
  logic                 rsp_err;
  logic [31:0]          PADDR;
  logic [31:0]          PWDATA;
  logic [15:0]          PSEL;
  logic                 PENABLE;
  logic                 PWRITE;
  logic                 PREADY;
  logic [31:0]          PRDATA;

  int total = 0;
  int bad   = 0;

  int          last;
  bit          b2b;
  logic [3:0]  sv;
  logic [31:0] sa [NR];
  logic [31:0] sd [NR];
  logic        sw [NR];

  apb_master_arb #(.NREQ(NR), .TIMEOUT(TMO)) dut (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_write (req_write),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PREADY    (PREADY),
    .PRDATA    (PRDATA)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge PCLK);
    #1;
  endtask

  function automatic int pick(logic [3:0] v, int lst);
    for (int i = 1; i <= NR; i++) begin
      int j;
      j = (lst + i) % NR;
      if (v[2'(j)]) return j;
    end
    return -1;
  endfunction

  function automatic void take_snap();
    sv = req_valid;
    for (int r = 0; r < NR; r++) begin
      sa[r] = req_addr[r];
      sd[r] = req_wdata[r];
      sw[r] = req_write[r];
    end
  endfunction

  task automatic xfer(input int nwait, input logic [31:0] rd,
                      input bit hold, input int ghost,
                      output logic [3:0] obs);
    int          w, k;
    bit          done, err;
    logic [31:0] ea, ed;
    logic        ew;
    logic [15:0] ep;
    if (!b2b) begin
      @(negedge PCLK);
      chk("idle_psel", 64'(PSEL), 64'(0));
      chk("idle_pen", 64'(PENABLE), 64'(0));
      take_snap();
      next();
    end
    w = pick(sv, last);
    if (w < 0) begin
      $display("FAIL bench_no_request observed=0 expected=1");
      $fatal(1, "no pending request");
    end
    ea = sa[w];
    ed = sd[w];
    ew = sw[w];
    ep = 16'h1 << ea[15:12];
    if (!hold) req_valid[2'(w)] = 1'b0;
    req_addr[2'(w)]  = $urandom;
    req_wdata[2'(w)] = $urandom;
    @(negedge PCLK);
    obs = req_ready;
    chk("setup_ready", 64'(req_ready), 64'(1) << w);
    chk("setup_psel", 64'(PSEL), 64'(ep));
    chk("setup_pen", 64'(PENABLE), 64'(0));
    chk("setup_paddr", 64'(PADDR), 64'(ea));
    chk("setup_pwdata", 64'(PWDATA), 64'(ed));
    chk("setup_pwrite", 64'(PWRITE), 64'(ew));
    chk("setup_rsp", 64'(rsp_valid), 64'(0));
    next();
    k = 0;
    done = 1'b0;
    err = 1'b0;
    while (!done) begin
      PREADY = (k == nwait);
      PRDATA = (k == nwait) ? rd : $urandom;
      if (ghost >= 0)
        req_valid[2'(ghost)] = !((k == nwait) || (k == TMO - 1));
      @(negedge PCLK);
      chk("acc_pen", 64'(PENABLE), 64'(1));
      chk("acc_psel", 64'(PSEL), 64'(ep));
      chk("acc_paddr", 64'(PADDR), 64'(ea));
      chk("acc_pwdata", 64'(PWDATA), 64'(ed));
      chk("acc_pwrite", 64'(PWRITE), 64'(ew));
      chk("acc_ready", 64'(req_ready), 64'(0));
      chk("acc_rsp", 64'(rsp_valid), 64'(0));
      if (k == nwait) done = 1'b1;
      else if (k == TMO - 1) begin
        done = 1'b1;
        err  = 1'b1;
      end
      k++;
      next();
    end
    PREADY = 1'b0;
    last = w;
    @(negedge PCLK);
    chk("rsp_valid", 64'(rsp_valid), 64'(1) << w);
    chk("rsp_err", 64'(rsp_err), 64'(err));
    chk("rsp_rdata", 64'(rsp_rdata), (ew || err) ? 64'(0) : 64'(rd));
    chk("rsp_psel", 64'(PSEL), 64'(0));
    chk("rsp_pen", 64'(PENABLE), 64'(0));
    chk("rsp_paddr_hold", 64'(PADDR), 64'(ea));
    chk("rsp_pwrite_hold", 64'(PWRITE), 64'(ew));
    take_snap();
    b2b = |sv;
    next();
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_psel"}, 64'(PSEL), 64'(0));
    chk({tag, "_pen"}, 64'(PENABLE), 64'(0));
    chk({tag, "_pwrite"}, 64'(PWRITE), 64'(0));
    chk({tag, "_paddr"}, 64'(PADDR), 64'(0));
    chk({tag, "_pwdata"}, 64'(PWDATA), 64'(0));
    chk({tag, "_ready"}, 64'(req_ready), 64'(0));
    chk({tag, "_rspv"}, 64'(rsp_valid), 64'(0));
    chk({tag, "_rdata"}, 64'(rsp_rdata), 64'(0));
    chk({tag, "_err"}, 64'(rsp_err), 64'(0));
  endtask

  initial begin
    logic [3:0] obs;
    int         ord [5];
    PRESETn   = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_write = '0;
    PREADY    = 1'b0;
    PRDATA    = '0;
    last      = NR - 1;
    b2b       = 1'b0;
    sv        = '0;
    ord       = '{0, 1, 2, 3, 0};

    // reset state
    @(posedge PCLK);
    @(posedge PCLK);
    @(negedge PCLK);
    chk_zero("reset");
    next();
    PRESETn = 1'b1;

    // single write from requester 0
    req_addr[0]  = 32'h0000_2010;
    req_wdata[0] = 32'hA5A5_0001;
    req_write[0] = 1'b1;
    req_valid    = 4'b0001;
    xfer(0, 32'h0, 1'b0, -1, obs);
    chk("write_grant", 64'(obs), 64'(4'b0001));

    // read with three wait states from requester 1
    req_addr[1]  = 32'h0000_5004;
    req_wdata[1] = 32'h0;
    req_write[1] = 1'b0;
    req_valid    = 4'b0010;
    xfer(3, 32'h1234_5678, 1'b0, -1, obs);

    // timeout on requester 2
    req_addr[2]  = 32'h0000_9100;
    req_write[2] = 1'b0;
    req_valid    = 4'b0100;
    xfer(100, 32'hFFFF_FFFF, 1'b0, -1, obs);
    @(negedge PCLK);
    chk("tmo_idle_psel", 64'(PSEL), 64'(0));
    chk("tmo_idle_rspv", 64'(rsp_valid), 64'(0));
    next();

    // requester 3 alone leaves pointer at 3
    req_addr[3]  = 32'h0000_F00C;
    req_wdata[3] = 32'h0BAD_F00D;
    req_write[3] = 1'b1;
    req_valid    = 4'b1000;
    xfer(1, 32'h0, 1'b0, -1, obs);

    // contention: everyone held valid
    for (int r = 0; r < NR; r++) req_write[r] = 1'(r & 1);
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      xfer(i % 2, $urandom, 1'b1, -1, obs);
      chk("rr_order", 64'(obs), 64'(1) << ord[i]);
    end
    req_valid = '0;
    xfer(0, $urandom, 1'b0, -1, obs);
    chk("rr_drain", 64'(obs), 64'(4'b0010));

    // random traffic with ghost requests
    for (int it = 0; it < 40; it++) begin
      int nw, gh;
      bit hd;
      if (!b2b) begin
        for (int r = 0; r < NR; r++) begin
          req_addr[r]  = $urandom;
          req_wdata[r] = $urandom;
          req_write[r] = 1'($urandom_range(0, 1));
        end
        req_valid = 4'($urandom_range(1, 15));
      end
      nw = ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(0, 3);
      hd = ($urandom_range(0, 3) == 0);
      gh = $urandom_range(0, NR - 1);
      if (req_valid[2'(gh)]) gh = -1;
      xfer(nw, $urandom, hd, gh, obs);
    end
    if (b2b) begin
      req_valid = '0;
      xfer(0, $urandom, 1'b0, -1, obs);
    end

    // reset in the middle of an access
    req_addr[0]  = 32'h0000_7ABC;
    req_wdata[0] = 32'hDEAD_BEEF;
    req_write[0] = 1'b1;
    req_valid    = 4'b0001;
    PREADY       = 1'b0;
    next();
    req_valid = '0;
    next();
    next();
    @(negedge PCLK);
    chk("pre_rst_psel", 64'(PSEL), 64'(16'h0080));
    chk("pre_rst_pen", 64'(PENABLE), 64'(1));
    @(posedge PCLK);
    #2;
    PRESETn = 1'b0;
    #1;
    chk_zero("async_rst");
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK);
      chk("rst_hold_rspv", 64'(rsp_valid), 64'(0));
      chk("rst_hold_psel", 64'(PSEL), 64'(0));
    end
    next();
    PRESETn = 1'b1;
    last    = NR - 1;
    b2b     = 1'b0;
    req_addr[1]  = 32'h0000_1010;
    req_write[1] = 1'b0;
    req_addr[3]  = 32'h0000_3030;
    req_wdata[3] = 32'h3333_0000;
    req_write[3] = 1'b1;
    req_valid    = 4'b1010;
    xfer(1, 32'hCAFE_0001, 1'b0, -1, obs);
    chk("post_rst_first", 64'(obs), 64'(4'b0010));
    xfer(0, 32'h0, 1'b0, -1, obs);
    chk("post_rst_second", 64'(obs), 64'(4'b1000));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
